// File: rtl/adc_uart_tx.sv
// adc_uart_tx: serializes ADC samples onto a UART line as 3-byte 8N1 frames.
// Each frame is a header byte {HDR_BASE[7:1], overflow}, then the sample MSB, then the sample LSB.
// A single-entry holding buffer accepts the next sample while the current frame is on the wire.
//
// Ports:
//   clkouta      in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_in    in   16-bit ADC sample
//   ofa_in       in   ADC overflow flag, captured together with sample_in
//   sample_valid in   producer offers sample_in/ofa_in
//   sample_ready out  holding buffer is empty (registered)
//   txd          out  UART serial output, idle high (registered)
//   busy         out  frame in progress (FSM not idle)
//   frame_cnt    out  completed frame count, wraps at 16 bits
module adc_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HDR_BASE     = 8'hA4
) (
    input  logic        clkouta,
    input  logic        rst_n,
    input  logic [15:0] sample_in,
    input  logic        ofa_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        txd,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMR_RELOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      r_state, w_state_n;
    logic [TW-1:0] r_timer, w_timer_n;
    logic [2:0]  r_bit_idx, w_bit_idx_n;
    logic [1:0]  r_byte_idx, w_byte_idx_n;
    logic [23:0] r_frame, w_frame_n;
    logic [15:0] r_hold_data;
    logic        r_hold_ofa;
    logic        r_hold_full, w_hold_full_n;
    logic        r_ready;
    logic        r_txd, w_txd_n;
    logic        r_busy;
    logic [15:0] r_frame_cnt;
    logic        w_xfer;
    logic        w_load;
    logic        w_frame_done;
    logic        w_tmr_zero;
    logic [7:0]  w_cur_byte;

    assign sample_ready = r_ready;
    assign txd          = r_txd;
    assign busy         = r_busy;
    assign frame_cnt    = r_frame_cnt;

    assign w_xfer     = sample_valid & r_ready;
    assign w_tmr_zero = (r_timer == '0);

    // Byte currently on the wire, header first
    always_comb begin
        case (r_byte_idx)
            2'd0:    w_cur_byte = r_frame[23:16];
            2'd1:    w_cur_byte = r_frame[15:8];
            default: w_cur_byte = r_frame[7:0];
        endcase
    end

    // State register
    always_ff @(posedge clkouta or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state, bit timer, and line level for the next cycle
    always_comb begin
        w_state_n    = r_state;
        w_timer_n    = r_timer;
        w_bit_idx_n  = r_bit_idx;
        w_byte_idx_n = r_byte_idx;
        w_frame_n    = r_frame;
        w_load       = 1'b0;
        w_frame_done = 1'b0;
        w_txd_n      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_frame_n    = {HDR_BASE[7:1], r_hold_ofa, r_hold_data};
                    w_byte_idx_n = 2'd0;
                    w_timer_n    = TMR_RELOAD;
                    w_state_n    = S_START;
                end
            end
            S_START: begin
                w_txd_n = 1'b0;
                if (w_tmr_zero) begin
                    w_timer_n   = TMR_RELOAD;
                    w_bit_idx_n = 3'd0;
                    w_state_n   = S_DATA;
                end else begin
                    w_timer_n = r_timer - TW'(1);
                end
            end
            S_DATA: begin
                w_txd_n = w_cur_byte[r_bit_idx];
                if (w_tmr_zero) begin
                    w_timer_n = TMR_RELOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer_n = r_timer - TW'(1);
                end
            end
            S_STOP: begin
                if (w_tmr_zero) begin
                    w_timer_n = TMR_RELOAD;
                    if (r_byte_idx < 2'd2) begin
                        w_byte_idx_n = r_byte_idx + 2'd1;
                        w_state_n    = S_START;
                    end else begin
                        w_frame_done = 1'b1;
                        w_state_n    = S_IDLE;
                    end
                end else begin
                    w_timer_n = r_timer - TW'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // Load empties the buffer; a capture can never coincide since ready is low while full
        w_hold_full_n = r_hold_full;
        if (w_load) begin
            w_hold_full_n = 1'b0;
        end
        if (w_xfer) begin
            w_hold_full_n = 1'b1;
        end
    end

    // Datapath, holding buffer and registered outputs
    always_ff @(posedge clkouta or negedge rst_n) begin
        if (!rst_n) begin
            r_timer     <= '0;
            r_bit_idx   <= 3'd0;
            r_byte_idx  <= 2'd0;
            r_frame     <= 24'd0;
            r_hold_data <= 16'd0;
            r_hold_ofa  <= 1'b0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_txd       <= 1'b1;
            r_busy      <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_timer     <= w_timer_n;
            r_bit_idx   <= w_bit_idx_n;
            r_byte_idx  <= w_byte_idx_n;
            r_frame     <= w_frame_n;
            r_hold_full <= w_hold_full_n;
            r_ready     <= ~w_hold_full_n;
            r_txd       <= w_txd_n;
            r_busy      <= (w_state_n != S_IDLE);
            if (w_xfer) begin
                r_hold_data <= sample_in;
                r_hold_ofa  <= ofa_in;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

endmodule
